// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// latency counter width and the "no write" byte-enable value.
package dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'b00,
    DMEM_ST_WAIT = 2'b01,
    DMEM_ST_RESP = 2'b10
  } dmem_state_e;

  localparam int          DMEM_CNT_W    = 4;
  localparam logic [3:0]  DMEM_WEN_NONE = 4'b0000;

endpackage

// File: rtl/dmem_array.sv
// Byte-writable word RAM: one synchronous write port with per-lane enables,
// one asynchronous read port for the access path and one for the debug path.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic [3:0]            wen,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [DEPTH_LOG2-1:0] taddr,
  output logic [31:0]           tdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_r [DEPTH];

  // Commit each enabled byte lane of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[addr];
  assign tdata = mem_r[taddr];

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: accepts one load/store at a time,
// commits byte-lane writes at acceptance and returns read data plus an
// error flag after a fixed latency. resetn is active-high and asynchronous.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);
  localparam logic [DMEM_CNT_W-1:0] CNT_ONE  = DMEM_CNT_W'(1);
  localparam logic [DMEM_CNT_W-1:0] CNT_ZERO = DMEM_CNT_W'(0);
  localparam int                    HI_W     = 32 - DEPTH_LOG2 - 2;

  dmem_state_e           state_r;
  logic [DMEM_CNT_W-1:0] cnt_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic [31:0]           rsp_rdata_r;
  logic                  rsp_err_r;

  logic                  accept_s;
  logic                  err_s;
  logic [3:0]            mem_wen_s;
  logic [31:0]           mem_rdata_s;
  logic [31:0]           rd_word_s;
  logic                  test_addr_unused_s;

  assign accept_s = req_valid & req_ready_r;

  // Flag misaligned addresses and anything beyond the last word (no wrap).
  always_comb begin
    err_s = 1'b0;
    if (req_addr[1:0] != 2'b00) begin
      err_s = 1'b1;
    end else if (req_addr[31:DEPTH_LOG2+2] != {HI_W{1'b0}}) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Only an accepted, in-range request may touch memory.
  always_comb begin
    mem_wen_s = DMEM_WEN_NONE;
    if (accept_s && !err_s) begin
      mem_wen_s = req_wen;
    end else begin
      mem_wen_s = DMEM_WEN_NONE;
    end
  end

  // Read data is returned only for clean loads; stores and errors give zero.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if ((req_wen == DMEM_WEN_NONE) && !err_s) begin
      rd_word_s = mem_rdata_s;
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .wen   (mem_wen_s),
    .addr  (req_addr[DEPTH_LOG2+1:2]),
    .wdata (req_wdata),
    .rdata (mem_rdata_s),
    .taddr (test_addr[DEPTH_LOG2+1:2]),
    .tdata (test_data)
  );

  // Debug port ignores byte offset and upper address bits by design.
  assign test_addr_unused_s = ^{test_addr[31:DEPTH_LOG2+2], test_addr[1:0]};

  // Transaction FSM, latency countdown and registered response outputs.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_r     <= DMEM_ST_IDLE;
      cnt_r       <= CNT_ZERO;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        DMEM_ST_IDLE: begin
          req_ready_r <= 1'b1;
          if (accept_s) begin
            req_ready_r <= 1'b0;
            rsp_rdata_r <= rd_word_s;
            rsp_err_r   <= err_s;
            if (LATENCY == 1) begin
              state_r     <= DMEM_ST_RESP;
              rsp_valid_r <= 1'b1;
              cnt_r       <= CNT_ZERO;
            end else begin
              state_r     <= DMEM_ST_WAIT;
              cnt_r       <= CNT_LOAD;
            end
          end
        end
        DMEM_ST_WAIT: begin
          if (cnt_r == CNT_ONE) begin
            state_r     <= DMEM_ST_RESP;
            rsp_valid_r <= 1'b1;
            cnt_r       <= CNT_ZERO;
          end else begin
            cnt_r       <= cnt_r - CNT_ONE;
          end
        end
        DMEM_ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= DMEM_ST_IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= DMEM_ST_IDLE;
          cnt_r       <= CNT_ZERO;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
